// File: rtl/program_dump_tx_pkg.sv
// Shared UART definitions for the program loader/dumper pair: state
// encoding, frame shape and the baud divisor floor.
package program_dump_tx_pkg;

   // One encoding for both the dump sequencer and the bit serializer so a
   // single debug view can show either.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_START   = 3'd3,
      ST_DATA    = 3'd4,
      ST_STOP    = 3'd5,
      ST_DONE    = 3'd6
   } uart_state_e;

   localparam int              DIV_W          = 20;
   localparam logic [DIV_W-1:0] DIV_MIN       = 20'd2;
   localparam int              DATA_BITS      = 8;
   localparam int              STOP_BITS      = 1;
   localparam int              BYTES_PER_WORD = 4;

   // Divisors below DIV_MIN would make a bit shorter than the counter can
   // represent, so they are lifted to the floor.
   function automatic logic [DIV_W-1:0] div_floor(input logic [DIV_W-1:0] d);
      return (d < DIV_MIN) ? DIV_MIN : d;
   endfunction

endpackage

// File: rtl/program_dump_tx_if.sv
// Synchronous ROM read port used by the program dumper. Read data is valid
// the cycle after rom_rd_o is high.
interface program_dump_tx_if #(
   parameter int ADDR_W = 15
);
   logic              rom_rd_o;
   logic [ADDR_W-1:0] rom_addr_o;
   logic [31:0]       rom_data_i;

   modport master (
      output rom_rd_o,
      output rom_addr_o,
      input  rom_data_i
   );

   modport slave (
      input  rom_rd_o,
      input  rom_addr_o,
      output rom_data_i
   );
endinterface

// File: rtl/program_dump_tx_serializer.sv
// 8N1 UART byte serializer: baud down-counter plus START/DATA/STOP bit
// sequencing, LSB first. tx_o is driven straight from a flop.
//
// Handshake: a byte is transferred on any cycle where load_i and ready_o
// are both high. ready_o is high while idle and during the final cycle of
// a stop bit, so a byte offered then starts its start bit on the very next
// cycle with no idle gap. load_i without ready_o is not remembered.
module uart_tx_serializer
   import program_dump_tx_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div_i,
   input  logic             load_i,
   input  logic [7:0]       byte_i,
   output logic             ready_o,
   output logic             tx_o,
   output uart_state_e      state_o
);

   uart_state_e      state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       sh_q, sh_d;
   logic [2:0]       bit_q, bit_d;
   logic             tx_q, tx_d;
   logic             bit_end;
   logic             accept;

   assign bit_end = (cnt_q == '0);
   assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
   assign accept  = load_i && ready_o;
   assign tx_o    = tx_q;
   assign state_o = state_q;

   // Next-state: bit timing, shifting and line level.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      tx_d    = tx_q;

      if ((state_q != ST_IDLE) && !bit_end) begin
         cnt_d = cnt_q - 1'b1;
      end

      if (accept) begin
         // The divisor is captured per frame; the start bit begins next cycle.
         state_d = ST_START;
         div_d   = div_i;
         cnt_d   = div_i - 1'b1;
         sh_d    = byte_i;
         bit_d   = '0;
         tx_d    = 1'b0;
      end else if (bit_end) begin
         case (state_q)
            ST_START: begin
               state_d = ST_DATA;
               cnt_d   = div_q - 1'b1;
               tx_d    = sh_q[0];
               sh_d    = {1'b0, sh_q[7:1]};
               bit_d   = '0;
            end
            ST_DATA: begin
               cnt_d = div_q - 1'b1;
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_d  = sh_q[0];
                  sh_d  = {1'b0, sh_q[7:1]};
                  bit_d = bit_q + 1'b1;
               end
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end
            default: begin
               tx_d = 1'b1;
            end
         endcase
      end
   end

   // State register; reset parks the line high immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         sh_q    <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/program_dump_tx.sv
// Program dump transmitter: reads ROM words and streams each one over the
// UART as four bytes, MSB byte first, optionally followed by an end-marker
// word. Bit-level framing is delegated to uart_tx_serializer.
module program_dump_tx
   import program_dump_tx_pkg::*;
#(
   parameter int          ADDR_W      = 15,
   parameter bit          SEND_MARKER = 1'b1,
   parameter logic [31:0] END_MARKER  = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  baudrate_i,
   input  logic              start_i,
   input  logic [ADDR_W:0]   word_count_i,
   program_dump_tx_if.master rom,
   output logic              tx_o,
   output logic              busy_o,
   output logic              done_o,
   output uart_state_e       dbg_state_o
);

   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

   // The sequencer uses ST_START for the whole time a word's four bytes are
   // with the serializer; the serializer reports the finer bit phase.
   uart_state_e      state_q, state_d;
   logic [ADDR_W:0]  cnt_q, cnt_d;
   logic [ADDR_W:0]  idx_q, idx_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [31:0]      shift_q, shift_d;
   logic [1:0]       bc_q, bc_d;
   logic             marker_q, marker_d;

   logic [ADDR_W:0]  word_sat;
   logic [ADDR_W:0]  idx_next;
   logic             in_marker;
   logic [31:0]      cap_word;
   logic             ser_load;
   logic [7:0]       ser_byte;
   logic             ser_ready;
   uart_state_e      ser_state;

   // Counts beyond the ROM size are clamped so the index can never wrap.
   assign word_sat  = (word_count_i > MAX_WORDS) ? MAX_WORDS : word_count_i;
   assign idx_next  = idx_q + 1'b1;
   // Once the index reaches the count, any further word is the marker.
   assign in_marker = !(idx_q < cnt_q);
   assign cap_word  = in_marker ? END_MARKER : rom.rom_data_i;

   assign rom.rom_rd_o   = (state_q == ST_FETCH) && !in_marker;
   assign rom.rom_addr_o = idx_q[ADDR_W-1:0];
   assign busy_o         = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done_o         = (state_q == ST_DONE);
   assign dbg_state_o    = (state_q == ST_START) ? ser_state : state_q;

   // Next-state: word fetch, byte hand-off and end-of-dump decisions.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      div_d    = div_q;
      shift_d  = shift_q;
      bc_d     = bc_q;
      marker_d = marker_q;
      ser_load = 1'b0;
      ser_byte = shift_q[23:16];

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               cnt_d    = word_sat;
               div_d    = div_floor(baudrate_i);
               idx_d    = '0;
               bc_d     = '0;
               marker_d = 1'b0;
               state_d  = ((word_sat == '0) && !SEND_MARKER) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // Byte 0 goes straight from the captured word so its start bit
            // follows CAPTURE without an extra cycle.
            shift_d  = cap_word;
            bc_d     = '0;
            ser_load = 1'b1;
            ser_byte = cap_word[31:24];
            if (in_marker) begin
               marker_d = 1'b1;
            end
            state_d = ST_START;
         end
         ST_START: begin
            if (ser_ready) begin
               if (bc_q != 2'(BYTES_PER_WORD - 1)) begin
                  bc_d     = bc_q + 1'b1;
                  shift_d  = {shift_q[23:0], 8'h00};
                  ser_load = 1'b1;
                  ser_byte = shift_q[23:16];
               end else if (!in_marker && (idx_next < cnt_q)) begin
                  idx_d   = idx_next;
                  state_d = ST_FETCH;
               end else if (SEND_MARKER && !marker_q) begin
                  if (!in_marker) begin
                     idx_d = idx_next;
                  end
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers; reset abandons any dump in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         div_q    <= '0;
         shift_q  <= '0;
         bc_q     <= '0;
         marker_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         div_q    <= div_d;
         shift_q  <= shift_d;
         bc_q     <= bc_d;
         marker_q <= marker_d;
      end
   end

   uart_tx_serializer u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .div_i   (div_q),
      .load_i  (ser_load),
      .byte_i  (ser_byte),
      .ready_o (ser_ready),
      .tx_o    (tx_o),
      .state_o (ser_state)
   );

endmodule

// File: tb/tb_program_dump_tx.sv
// Bench for program_dump_tx: two instances (marker off / marker on), a ROM
// model, a UART line monitor and a reference model of the byte stream and
// frame timing.
module tb_program_dump_tx;
   import program_dump_tx_pkg::*;

   localparam int          AW     = 4;
   localparam int          NW     = 1 << AW;
   localparam logic [31:0] MARKER = 32'hDEAD_BEEF;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT wiring ----------------
   logic [19:0] baud[2];
   logic        start[2];
   logic [AW:0] wcount[2];
   logic        tx[2];
   logic        busy[2];
   logic        done[2];
   uart_state_e dbg[2];
   logic [31:0] mem[NW];

   program_dump_tx_if #(.ADDR_W(AW)) rom0 ();
   program_dump_tx_if #(.ADDR_W(AW)) rom1 ();

   program_dump_tx #(.ADDR_W(AW), .SEND_MARKER(1'b0), .END_MARKER(MARKER)) dut0 (
      .clk(clk), .rst_n(rst_n), .baudrate_i(baud[0]), .start_i(start[0]),
      .word_count_i(wcount[0]), .rom(rom0), .tx_o(tx[0]), .busy_o(busy[0]),
      .done_o(done[0]), .dbg_state_o(dbg[0])
   );

   program_dump_tx #(.ADDR_W(AW), .SEND_MARKER(1'b1), .END_MARKER(MARKER)) dut1 (
      .clk(clk), .rst_n(rst_n), .baudrate_i(baud[1]), .start_i(start[1]),
      .word_count_i(wcount[1]), .rom(rom1), .tx_o(tx[1]), .busy_o(busy[1]),
      .done_o(done[1]), .dbg_state_o(dbg[1])
   );

   // ROM model: data valid the cycle after a read, garbage otherwise.
   always @(posedge clk) begin
      if (rom0.rom_rd_o) rom0.rom_data_i <= mem[rom0.rom_addr_o];
      else               rom0.rom_data_i <= 32'($urandom());
      if (rom1.rom_rd_o) rom1.rom_data_i <= mem[rom1.rom_addr_o];
      else               rom1.rom_data_i <= 32'($urandom());
   end

   // ---------------- scoreboard state ----------------
   int         n_tests = 0;
   int         n_fail  = 0;
   int         act     = 0;
   int         cur_div = 2;
   logic [7:0] rx_q[$];
   int         fs_q[$];
   int         done_q[$];
   logic       done_busy_q[$];
   int         rd_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- line monitor ----------------
   // Samples every cycle of a frame: each bit must hold for exactly the
   // divisor, start low, stop high. Frames cut by reset are discarded.
   task automatic rx_frame(input int c0);
      logic [9:0] v;
      bit         stable;
      bit         aborted;
      int         dv;
      dv      = cur_div;
      v       = '0;
      stable  = 1'b1;
      aborted = 1'b0;
      v[0]    = tx[act];
      for (int k = 1; k < 10 * dv; k++) begin
         @(negedge clk);
         if (!rst_n) aborted = 1'b1;
         if (k % dv == 0) v[k / dv] = tx[act];
         else if (tx[act] != v[k / dv]) stable = 1'b0;
      end
      if (!aborted) begin
         check("stop_bit", v[9], 1'b1);
         check("bit_stable", stable, 1'b1);
         rx_q.push_back(v[8:1]);
         fs_q.push_back(c0);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && (tx[act] == 1'b0)) rx_frame(cyc);
      end
   end

   always @(negedge clk) begin
      if (done[act]) begin
         done_q.push_back(cyc);
         done_busy_q.push_back(busy[act]);
      end
      if ((act == 0) && rom0.rom_rd_o) rd_q.push_back(int'(rom0.rom_addr_o));
      if ((act == 1) && rom1.rom_rd_o) rd_q.push_back(int'(rom1.rom_addr_o));
   end

   // ---------------- driver + reference model ----------------
   task automatic run_dump(input int d, input int bd, input int wc, input bit poke);
      logic [31:0] words[$];
      logic [7:0]  exp_q[$];
      int          exp_fs[$];
      int          n, s, t, dv, exp_done, guard;
      act     = d;
      dv      = (bd < 2) ? 2 : bd;
      cur_div = dv;
      rx_q.delete(); fs_q.delete(); done_q.delete(); done_busy_q.delete(); rd_q.delete();

      // Expected stream: n ROM words (clamped to ROM size) then the marker.
      n = (wc > NW) ? NW : wc;
      for (int i = 0; i < n; i++) words.push_back(mem[i]);
      if (d == 1) words.push_back(MARKER);
      t = 0;
      for (int i = 0; i < words.size(); i++) begin
         if (i > 0) t += 2;
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back(words[i][31 - 8 * b -: 8]);
            exp_fs.push_back(t + 3);
            t += 10 * dv;
         end
      end
      exp_done = (words.size() == 0) ? 1 : t + 3;

      @(negedge clk);
      baud[d]   = 20'(bd);
      wcount[d] = (AW + 1)'(wc);
      start[d]  = 1'b1;
      s         = cyc;
      @(negedge clk);
      start[d] = 1'b0;
      check("busy_after_start", busy[d], words.size() != 0);

      guard = 0;
      while ((done_q.size() == 0) && (guard < 20000)) begin
         @(negedge clk);
         guard++;
         if (poke && (guard == 25)) begin
            start[d]  = 1'b1;
            wcount[d] = (AW + 1)'(5);
            baud[d]   = 20'd7;
         end
         if (poke && (guard == 26)) start[d] = 1'b0;
      end
      repeat (30) @(negedge clk);

      check("done_seen", done_q.size() != 0, 1'b1);
      check("done_count", done_q.size(), 1);
      if (done_q.size() > 0) begin
         check("done_cycle", done_q[0] - s, exp_done);
         check("busy_at_done", done_busy_q[0], 1'b0);
      end
      check("rd_count", rd_q.size(), n);
      for (int i = 0; i < rd_q.size() && i < n; i++) check("rd_addr", rd_q[i], i);
      check("byte_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         check("byte", rx_q[i], exp_q[i]);
         check("frame_start", fs_q[i] - s, exp_fs[i]);
      end
      check("busy_idle", busy[d], 1'b0);
      check("tx_idle", tx[d], 1'b1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] w;
      int          lb_div, guard;

      for (int d = 0; d < 2; d++) begin
         baud[d] = '0; start[d] = 1'b0; wcount[d] = '0;
      end
      for (int i = 0; i < NW; i++) mem[i] = 32'($urandom());

      // Reset values.
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_tx", tx[d], 1'b1);
         check("rst_busy", busy[d], 1'b0);
         check("rst_done", done[d], 1'b0);
         check("rst_state", dbg[d], ST_IDLE);
      end
      check("rst_rd0", rom0.rom_rd_o, 1'b0);
      check("rst_addr0", rom0.rom_addr_o, 0);
      check("rst_rd1", rom1.rom_rd_o, 1'b0);
      check("rst_addr1", rom1.rom_addr_o, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single word, marker off.
      mem[0] = 32'h1234_5678;
      run_dump(0, 4, 1, 1'b0);

      // Two words plus marker.
      mem[0] = 32'hA5A5_A5A5;
      mem[1] = 32'h0000_0001;
      run_dump(1, 3, 2, 1'b0);

      // Divisor floor and empty dumps.
      run_dump(0, 0, 0, 1'b0);
      run_dump(0, 1, 2, 1'b0);
      run_dump(1, 0, 0, 1'b0);

      // Start while busy is ignored.
      run_dump(0, 2, 3, 1'b1);

      // Reset in the middle of data bit 3 of the first byte.
      mem[0][27] = 1'b0;
      act     = 1;
      cur_div = 4;
      @(negedge clk);
      baud[1] = 20'd4; wcount[1] = (AW + 1)'(2); start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      guard = 0;
      while (tx[1] && (guard < 100)) begin
         @(negedge clk);
         guard++;
      end
      check("rst_frame_seen", tx[1], 1'b0);
      repeat (17) @(negedge clk);
      check("pre_rst_tx", tx[1], 1'b0);
      check("pre_rst_busy", busy[1], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_tx", tx[1], 1'b1);
      check("rst_async_busy", busy[1], 1'b0);
      check("rst_async_state", dbg[1], ST_IDLE);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run_dump(1, 4, 2, 1'b0);
      check("rst_first_byte", (rx_q.size() > 0) ? rx_q[0] : 8'h00, mem[0][31:24]);

      // Loopback: reassemble eight words from the line.
      for (int i = 0; i < NW; i++) mem[i] = 32'($urandom());
      lb_div = $urandom_range(2, 6);
      run_dump(0, lb_div, 8, 1'b0);
      for (int i = 0; i < 8; i++) begin
         w = 32'h0;
         if (rx_q.size() >= 4 * i + 4)
            w = {rx_q[4 * i], rx_q[4 * i + 1], rx_q[4 * i + 2], rx_q[4 * i + 3]};
         check("loopback_word", w, mem[i]);
      end

      // Count above the ROM size clamps to the ROM size.
      run_dump(1, 2, 31, 1'b0);

      // Randomized dumps.
      for (int it = 0; it < 5; it++) begin
         for (int i = 0; i < NW; i++) mem[i] = 32'($urandom());
         run_dump($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 20), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound.
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
